// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the three-program sequencer: program start addresses,
// widths and the FSM state type.
package prog_sequencer_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RST_W  = 4;

    localparam logic [ADDR_W-1:0] PROG_START_0 = 8'd0;
    localparam logic [ADDR_W-1:0] PROG_START_1 = 8'd25;
    localparam logic [ADDR_W-1:0] PROG_START_2 = 8'd44;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        RUN    = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

    // PC load value for a program index; index 3 is unreachable
    function automatic logic [ADDR_W-1:0] prog_start(input logic [SEL_W-1:0] sel);
        case (sel)
            2'd0:    prog_start = PROG_START_0;
            2'd1:    prog_start = PROG_START_1;
            default: prog_start = PROG_START_2;
        endcase
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the program sequencer and whoever launches it.
interface prog_sequencer_if;
    import prog_sequencer_pkg::*;

    logic              start;
    logic              done_in;
    logic              core_rst;
    logic [SEL_W-1:0]  prog_sel;
    logic [ADDR_W-1:0] start_addr;
    logic              busy;
    logic              all_done;
    logic              timeout;
    logic [CNT_W-1:0]  cyc0;
    logic [CNT_W-1:0]  cyc1;
    logic [CNT_W-1:0]  cyc2;

    modport master (
        output start, done_in,
        input  core_rst, prog_sel, start_addr, busy, all_done, timeout, cyc0, cyc1, cyc2
    );

    modport slave (
        input  start, done_in,
        output core_rst, prog_sel, start_addr, busy, all_done, timeout, cyc0, cyc1, cyc2
    );
endinterface

// File: rtl/cyc_counter.sv
// Free-running RUN-cycle counter with a compare against the timeout limit.
module cyc_counter
    import prog_sequencer_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_limit = (count == TIMEOUT);

endmodule

// File: rtl/prog_sequencer.sv
// Launches programs 0,1,2 on the core in turn: reset pulse, run until halt or
// timeout, record the run length of each program.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned      RST_CYCLES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT    = 16'hFFFF
) (
    input  logic            clk,
    input  logic            reset,
    prog_sequencer_if.slave bus
);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    seq_state_t                  state, state_n;
    logic [RST_W-1:0]            rst_cnt, rst_cnt_n;
    logic [SEL_W-1:0]            sel, sel_n;
    logic                        to_q, to_n;
    logic [2:0][CNT_W-1:0]       cyc_q, cyc_n;
    logic                        core_rst_q, busy_q, all_done_q;
    logic                        cnt_clear, cnt_en, at_limit;
    logic [CNT_W-1:0]            count;

    cyc_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (count),
        .at_limit (at_limit)
    );

    // State and status registers; outputs follow the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            sel        <= '0;
            to_q       <= 1'b0;
            cyc_q      <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            state      <= state_n;
            rst_cnt    <= rst_cnt_n;
            sel        <= sel_n;
            to_q       <= to_n;
            cyc_q      <= cyc_n;
            core_rst_q <= (state_n == IDLE) || (state_n == RST);
            busy_q     <= (state_n == RST) || (state_n == RUN) || (state_n == NEXT);
            all_done_q <= (state_n == FINISH);
        end
    end

    // Next-state logic; done_in has precedence over the timeout compare
    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        sel_n     = sel;
        to_n      = to_q;
        cyc_n     = cyc_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        case (state)
            IDLE, FINISH: begin
                if (bus.start) begin
                    state_n   = RST;
                    rst_cnt_n = '0;
                    sel_n     = '0;
                    to_n      = 1'b0;
                    cyc_n     = '0;
                end
            end
            RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_n = RUN;
                end else begin
                    rst_cnt_n = rst_cnt + RST_W'(1);
                end
            end
            RUN: begin
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (bus.done_in) begin
                    state_n    = NEXT;
                    cyc_n[sel] = count;
                end else if (at_limit) begin
                    state_n    = NEXT;
                    cyc_n[sel] = TIMEOUT;
                    to_n       = 1'b1;
                end
            end
            NEXT: begin
                if (sel == SEL_W'(2)) begin
                    state_n = FINISH;
                end else begin
                    sel_n     = sel + SEL_W'(1);
                    rst_cnt_n = '0;
                    state_n   = RST;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.core_rst   = core_rst_q;
    assign bus.prog_sel   = sel;
    assign bus.start_addr = prog_start(sel);
    assign bus.busy       = busy_q;
    assign bus.all_done   = all_done_q;
    assign bus.timeout    = to_q;
    assign bus.cyc0       = cyc_q[0];
    assign bus.cyc1       = cyc_q[1];
    assign bus.cyc2       = cyc_q[2];

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: vector table, random sequences and
// hand-written reset/abort cases against a per-program run-length model.
module tb_prog_sequencer;

    localparam int unsigned RSTC = 2;
    localparam int          T    = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prog_sequencer_if bus();

    prog_sequencer #(.RST_CYCLES(RSTC), .TIMEOUT(16'(T))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int d0, d1, d2;     // RUN cycle index of done_in per program, -1 = never
        int c0, c1, c2;     // expected captured cycle counts
        bit to;             // expected sticky timeout
        bit noise;          // toggle done_in outside RUN
        bit poke;           // pulse start during program 1 RUN
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int addr_of(input int p);
        return (p == 0) ? 0 : (p == 1) ? 25 : 44;
    endfunction

    function automatic int cap_of(input int d);
        return (d < 0 || d > T) ? T : d;
    endfunction

    function automatic logic [15:0] cyc_of(input int p);
        return (p == 0) ? bus.cyc0 : (p == 1) ? bus.cyc1 : bus.cyc2;
    endfunction

    // One full launch; abort_at >= 0 fires reset at that RUN index of program 2
    task automatic run_seq(input vec_t v, input int abort_at);
        int d[3];
        int c[3];
        int rstc;
        d = '{v.d0, v.d1, v.d2};
        c = '{v.c0, v.c1, v.c2};
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_clears_timeout", bus.timeout, 0);
        check("start_clears_cyc", 32'(bus.cyc0 | bus.cyc1 | bus.cyc2), 0);
        for (int p = 0; p < 3; p++) begin
            rstc = 0;
            while (bus.core_rst === 1'b1 && rstc < 16) begin
                check("rst_prog_sel", bus.prog_sel, p);
                check("rst_start_addr", bus.start_addr, addr_of(p));
                check("rst_busy", bus.busy, 1);
                if (v.noise) bus.done_in = 1'($urandom_range(0, 1));
                rstc++;
                step();
            end
            bus.done_in = 1'b0;
            check("rst_len", rstc, RSTC);
            for (int k = 0; k <= c[p]; k++) begin
                if (p == 2 && k == abort_at) begin
                    reset       = 1'b1;
                    bus.done_in = 1'b1;
                    bus.start   = 1'b1;
                    step();
                    reset       = 1'b0;
                    bus.done_in = 1'b0;
                    bus.start   = 1'b0;
                    check("abort_busy", bus.busy, 0);
                    check("abort_core_rst", bus.core_rst, 1);
                    check("abort_cyc2", bus.cyc2, 0);
                    check("abort_cyc0", bus.cyc0, 0);
                    check("abort_prog_sel", bus.prog_sel, 0);
                    check("abort_all_done", bus.all_done, 0);
                    return;
                end
                check("run_no_early_capture", cyc_of(p), 0);
                check("run_core_rst", bus.core_rst, 0);
                bus.done_in = (k == d[p]);
                if (v.poke && p == 1 && k == 0) bus.start = 1'b1;
                step();
                bus.done_in = 1'b0;
                bus.start   = 1'b0;
            end
            check("cyc_capture", cyc_of(p), c[p]);
            check("next_busy", bus.busy, 1);
            if (v.noise) bus.done_in = 1'($urandom_range(0, 1));
            step();
            bus.done_in = 1'b0;
        end
        check("fin_all_done", bus.all_done, 1);
        check("fin_busy", bus.busy, 0);
        check("fin_prog_sel", bus.prog_sel, 2);
        check("fin_timeout", bus.timeout, 32'(v.to));
        for (int h = 0; h < 2; h++) begin
            bus.done_in = 1'b1;
            step();
        end
        bus.done_in = 1'b0;
        check("hold_all_done", bus.all_done, 1);
        check("hold_cyc0", bus.cyc0, v.c0);
        check("hold_cyc1", bus.cyc1, v.c1);
        check("hold_cyc2", bus.cyc2, v.c2);
        check("hold_timeout", bus.timeout, 32'(v.to));
    endtask

    vec_t vecs[5];
    vec_t rv;

    initial begin
        vecs[0] = '{d0:10, d1:10, d2:10, c0:10, c1:10, c2:10, to:1'b0, noise:1'b0, poke:1'b0};
        vecs[1] = '{d0:-1, d1:-1, d2:-1, c0:T,  c1:T,  c2:T,  to:1'b1, noise:1'b0, poke:1'b0};
        vecs[2] = '{d0:T,  d1:T,  d2:T,  c0:T,  c1:T,  c2:T,  to:1'b0, noise:1'b1, poke:1'b0};
        vecs[3] = '{d0:0,  d1:19, d2:21, c0:0,  c1:19, c2:T,  to:1'b1, noise:1'b1, poke:1'b1};
        vecs[4] = '{d0:5,  d1:7,  d2:3,  c0:5,  c1:7,  c2:3,  to:1'b0, noise:1'b0, poke:1'b1};

        bus.start   = 1'b0;
        bus.done_in = 1'b0;
        reset       = 1'b1;
        step();
        bus.start   = 1'b1;
        bus.done_in = 1'b1;
        step();
        bus.start   = 1'b0;
        check("reset_core_rst", bus.core_rst, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_all_done", bus.all_done, 0);
        check("reset_prog_sel", bus.prog_sel, 0);
        check("reset_start_addr", bus.start_addr, 0);
        check("reset_timeout", bus.timeout, 0);
        check("reset_cyc", 32'(bus.cyc0 | bus.cyc1 | bus.cyc2), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.done_in = 1'b0;
        check("idle_core_rst", bus.core_rst, 1);
        check("idle_busy", bus.busy, 0);

        foreach (vecs[i]) run_seq(vecs[i], -1);

        // reset in the middle of program 2, then a clean relaunch from IDLE
        run_seq(vecs[0], 4);
        run_seq(vecs[4], -1);

        for (int r = 0; r < 6; r++) begin
            rv.d0 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 3));
            rv.d1 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 3));
            rv.d2 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T + 3));
            rv.c0 = cap_of(rv.d0);
            rv.c1 = cap_of(rv.d1);
            rv.c2 = cap_of(rv.d2);
            rv.to = (rv.d0 < 0 || rv.d0 > T) || (rv.d1 < 0 || rv.d1 > T) || (rv.d2 < 0 || rv.d2 > T);
            rv.noise = 1'b1;
            rv.poke  = 1'($urandom_range(0, 1));
            run_seq(rv, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
